scaler_h: RTL and testbench

Horizontal cubic (Catmull-Rom) image scaler for a single-component pixel stream, typically 8-bit Bayer or mono. It sits in the video pipeline between a line-timed source and the vertical scaler or an image monitor. It resamples each line by a runtime fixed-point step and passes line/frame markers through with matched latency.

---
 rtl/scaler_h_pkg.sv | 31 +++
 rtl/scaler_h_coe.sv | 45 ++++
 rtl/scaler_h.sv | 135 +++++++++++++
 tb/tb_scaler_h.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/scaler_h_pkg.sv
// Shared widths, latency and payload types for the horizontal Catmull-Rom scaler.
package scaler_h_pkg;
    localparam int unsigned PIXEL_STEP  = 128;
    localparam int unsigned PIXEL_WIDTH = 8;
    localparam int unsigned COE_WIDTH   = 8;
    localparam int unsigned FRAC_W      = $clog2(PIXEL_STEP);
    localparam int unsigned COE_W       = COE_WIDTH + 2;
    localparam int unsigned ACC_W       = PIXEL_WIDTH + COE_WIDTH + 5;
    localparam int unsigned IDX_W       = 17;
    localparam int unsigned POS_W       = IDX_W + FRAC_W;
    localparam int unsigned LAT         = 5;

    typedef logic signed [COE_W-1:0] coe_t;
    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic [PIXEL_WIDTH-1:0]  pix_t;

    // x0 is the oldest tap (x[i-1]), x3 the newest (x[i+2])
    typedef struct packed {
        pix_t x0;
        pix_t x1;
        pix_t x2;
        pix_t x3;
    } taps_t;

    typedef struct packed {
        coe_t w0;
        coe_t w1;
        coe_t w2;
        coe_t w3;
    } coe_set_t;
endpackage

// File: rtl/scaler_h_coe.sv
// Registered Catmull-Rom weight generator: fraction f -> (w0..w3), sum fixed to unity.
module scaler_h_coe
    import scaler_h_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FRAC_W-1:0] frac,
    output coe_set_t          coe
);
    // Polynomials are evaluated with numerators scaled by 2^SH, then rounded to nearest
    localparam int unsigned        SH    = 3 * FRAC_W - COE_WIDTH + 1;
    localparam logic signed [31:0] HALF  = 32'sd1 <<< (SH - 1);
    localparam logic signed [31:0] UNITY = 32'sd1 <<< COE_WIDTH;

    logic signed [31:0] f1, f2, f3;
    logic signed [31:0] n0, n2, n3;
    logic signed [31:0] r0, r1, r2, r3;
    coe_set_t           coe_c;

    always_comb begin
        f1 = 32'(frac);
        f2 = f1 * f1;
        f3 = f2 * f1;
        n0 = -f3 + (f2 <<< (FRAC_W + 1)) - (f1 <<< (2 * FRAC_W));
        n2 = -(32'sd3 * f3) + (f2 <<< (FRAC_W + 2)) + (f1 <<< (2 * FRAC_W));
        n3 = f3 - (f2 <<< FRAC_W);
        r0 = (n0 + HALF) >>> SH;
        r2 = (n2 + HALF) >>> SH;
        r3 = (n3 + HALF) >>> SH;
        // w1 absorbs the rounding residue so the set sums to exactly unity
        r1 = UNITY - r0 - r2 - r3;
        coe_c.w0 = coe_t'(r0);
        coe_c.w1 = coe_t'(r1);
        coe_c.w2 = coe_t'(r2);
        coe_c.w3 = coe_t'(r3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coe <= '0;
        end else begin
            coe <= coe_c;
        end
    end
endmodule

// File: rtl/scaler_h.sv
// Horizontal cubic (Catmull-Rom) scaler, 5-cycle pipeline with matched hs/vs delay.
// Define SCALER_H_ROUND_EN for round-half-up; otherwise the result is floored.
module scaler_h
    import scaler_h_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            scale_step,
    input  logic [PIXEL_WIDTH-1:0] di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o
);
    localparam int unsigned CMP_W = IDX_W + 1;
`ifdef SCALER_H_ROUND_EN
    localparam acc_t RND = acc_t'(1 << (COE_WIDTH - 1));
`else
    localparam acc_t RND = '0;
`endif
    localparam acc_t PIX_MAX = acc_t'((1 << PIXEL_WIDTH) - 1);

    taps_t            win, win_nxt;
    logic [POS_W-1:0] pos, pos_cur, pos_nxt;
    logic [IDX_W-1:0] n_cnt, n_eff;
    logic [15:0]      step_r, step_new, step_eff;
    logic [CMP_W-1:0] ip2, idx;
    logic             active, emit, adv;

    logic              s1_vld, s2_vld, s3_vld, s4_vld;
    logic [FRAC_W-1:0] s1_f;
    taps_t             s1_taps, s2_taps;
    coe_set_t          coe;
    acc_t              p0, p1, p2, p3, s4, rnd_sh;
    pix_t              res;
    logic [LAT-1:0]    hs_sr, vs_sr;

    // Output position generator: emit while the current position needs exactly the newest input
    always_comb begin
        step_new = (scale_step == 16'd0) ? 16'(PIXEL_STEP) : scale_step;
        step_eff = hs_i ? step_new : step_r;
        pos_cur  = hs_i ? '0 : pos;
        n_eff    = (hs_i ? '0 : n_cnt) + IDX_W'(de_i);
        idx      = CMP_W'(n_eff) - CMP_W'(1);
        ip2      = CMP_W'(pos_cur[POS_W-1:FRAC_W]) + CMP_W'(2);
        active   = (n_eff != '0);
        emit     = active && (ip2 == idx);
        // Positions left behind by an overriding input are discarded without output
        adv      = active && (ip2 <= idx);
        pos_nxt  = adv ? pos_cur + POS_W'(step_eff) : pos_cur;
        win_nxt  = win;
        if (de_i) begin
            // First pixel of a line fills the window so that x[-1] = x[0]
            win_nxt = (n_eff == IDX_W'(1)) ? {di_i, di_i, di_i, di_i}
                                           : {win.x1, win.x2, win.x3, di_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win     <= '0;
            pos     <= '0;
            n_cnt   <= '0;
            step_r  <= 16'(PIXEL_STEP);
            s1_vld  <= 1'b0;
            s1_f    <= '0;
            s1_taps <= '0;
        end else begin
            win     <= win_nxt;
            pos     <= pos_nxt;
            n_cnt   <= n_eff;
            if (hs_i) step_r <= step_new;
            s1_vld  <= emit;
            s1_f    <= pos_cur[FRAC_W-1:0];
            s1_taps <= win_nxt;
        end
    end

    scaler_h_coe u_coe (
        .clk   (clk),
        .rst_n (rst_n),
        .frac  (s1_f),
        .coe   (coe)
    );

    always_comb begin
        rnd_sh = (s4 + RND) >>> COE_WIDTH;
        if (rnd_sh[ACC_W-1]) begin
            res = '0;
        end else if (rnd_sh > PIX_MAX) begin
            res = '1;
        end else begin
            res = PIXEL_WIDTH'(rnd_sh);
        end
    end

    // Taps follow weights, then multiply, sum and round/clamp stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld  <= 1'b0;
            s2_taps <= '0;
            s3_vld  <= 1'b0;
            p0      <= '0;
            p1      <= '0;
            p2      <= '0;
            p3      <= '0;
            s4_vld  <= 1'b0;
            s4      <= '0;
            de_o    <= 1'b0;
            do_o    <= '0;
            hs_sr   <= '0;
            vs_sr   <= '0;
        end else begin
            s2_vld  <= s1_vld;
            s2_taps <= s1_taps;
            s3_vld  <= s2_vld;
            p0      <= acc_t'(coe.w0) * acc_t'({1'b0, s2_taps.x0});
            p1      <= acc_t'(coe.w1) * acc_t'({1'b0, s2_taps.x1});
            p2      <= acc_t'(coe.w2) * acc_t'({1'b0, s2_taps.x2});
            p3      <= acc_t'(coe.w3) * acc_t'({1'b0, s2_taps.x3});
            s4_vld  <= s3_vld;
            s4      <= p0 + p1 + p2 + p3;
            de_o    <= s4_vld;
            do_o    <= s4_vld ? res : '0;
            hs_sr   <= {hs_sr[LAT-2:0], hs_i};
            vs_sr   <= {vs_sr[LAT-2:0], vs_i};
        end
    end

    assign hs_o = hs_sr[LAT-1];
    assign vs_o = vs_sr[LAT-1];
endmodule

// File: tb/tb_scaler_h.sv
// Scoreboard bench for scaler_h: reference interpolation in real arithmetic, latency-tagged expectations.
module tb_scaler_h;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [15:0] scale_step;
    logic [7:0] di_i;
    logic       de_i, hs_i, vs_i;
    logic [7:0] do_o;
    logic       de_o, hs_o, vs_o;

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t       sb[$];
    int         px[0:63];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         out_cnt = 0;
    int         vs_cnt = 0;
    logic [4:0] hist_hs = '0;
    logic [4:0] hist_vs = '0;

    scaler_h dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scale_step (scale_step),
        .di_i       (di_i),
        .de_i       (de_i),
        .hs_i       (hs_i),
        .vs_i       (vs_i),
        .do_o       (do_o),
        .de_o       (de_o),
        .hs_o       (hs_o),
        .vs_o       (vs_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int tap(input int i);
        return px[(i < 0) ? 0 : i];
    endfunction

    // Reference: Catmull-Rom weights rounded to 1/256, residue in w1
    function automatic int model_px(input int i, input int f);
        real t;
        int  w0, w1, w2, w3, acc, v;
        t   = f / 128.0;
        w0  = int'($floor(128.0 * (-t*t*t + 2.0*t*t - t) + 0.5));
        w2  = int'($floor(128.0 * (-3.0*t*t*t + 4.0*t*t + t) + 0.5));
        w3  = int'($floor(128.0 * (t*t*t - t*t) + 0.5));
        w1  = 256 - w0 - w2 - w3;
        acc = w0 * tap(i - 1) + w1 * tap(i) + w2 * tap(i + 1) + w3 * tap(i + 2);
`ifdef SCALER_H_ROUND_EN
        acc = acc + 128;
`endif
        v = acc >>> 8;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return v;
    endfunction

    task automatic tick();
        exp_t e;
        logic exp_de;
        hist_hs = {hist_hs[3:0], hs_i};
        hist_vs = {hist_vs[3:0], vs_i};
        @(posedge clk);
        #1;
        cyc++;
        check("hs_o", 32'(hs_o), 32'(hist_hs[4]));
        check("vs_o", 32'(vs_o), 32'(hist_vs[4]));
        if (vs_o) vs_cnt++;
        exp_de = (sb.size() != 0) && (sb[0].due == cyc);
        check("de_o", 32'(de_o), 32'(exp_de));
        if (de_o) out_cnt++;
        if (exp_de) begin
            e = sb.pop_front();
            if (de_o) check("do_o", 32'(do_o), 32'(e.val));
        end
    endtask

    // Drives `count` pixels of one line from px[], pushing the outputs each input triggers
    task automatic run_line(input int count, input int step, input int gap, input bit first);
        int   kpos, seff, j;
        exp_t e;
        seff = (step == 0) ? 128 : step;
        kpos = 0;
        for (int n = 0; n < count; n++) begin
            de_i = 1'b1;
            di_i = 8'(px[n]);
            hs_i = (n == 0);
            vs_i = (n == 0) && first;
            scale_step = 16'(step);
            j = 0;
            while ((kpos >> 7) + 2 == n) begin
                e.val = model_px(kpos >> 7, kpos % 128);
                e.due = cyc + 5 + j;
                sb.push_back(e);
                kpos += seff;
                j++;
            end
            tick();
            de_i = 1'b0;
            hs_i = 1'b0;
            vs_i = 1'b0;
            di_i = 8'($urandom);
            repeat (gap) tick();
        end
    endtask

    task automatic line_check(input string tag, input int count, input int step, input int gap,
                              input bit first, input int exp_cnt);
        out_cnt = 0;
        run_line(count, step, gap, first);
        repeat (10) tick();
        check(tag, 32'(out_cnt), 32'(exp_cnt));
    endtask

    initial begin
        rst_n = 1'b0;
        scale_step = 16'd128;
        di_i = '0;
        de_i = 1'b0;
        hs_i = 1'b0;
        vs_i = 1'b0;
        #2;
        check("rst_do", 32'(do_o), 32'd0);
        check("rst_de", 32'(de_o), 32'd0);
        check("rst_hs", 32'(hs_o), 32'd0);
        check("rst_vs", 32'(vs_o), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Identity: ramp, one output per input, do_o = k
        for (int n = 0; n < 64; n++) px[n] = n;
        line_check("cnt_identity", 24, 128, 0, 1'b1, 22);

        // Downscale of a flat line
        for (int n = 0; n < 64; n++) px[n] = 200;
        line_check("cnt_down", 24, 179, 0, 1'b1, 16);

        // 2x upscale with one idle cycle between inputs
        for (int n = 0; n < 64; n++) px[n] = 10 * n;
        line_check("cnt_up", 12, 64, 1, 1'b0, 20);

        // Negative lobes must clamp at zero
        px[0] = 255; px[1] = 0; px[2] = 0; px[3] = 255;
        line_check("cnt_clamp", 4, 64, 1, 1'b0, 4);

        // Step 0 behaves as unity pitch
        for (int n = 0; n < 64; n++) px[n] = $urandom_range(0, 255);
        line_check("cnt_step0", 8, 0, 0, 1'b0, 6);

        // Reset in the middle of a line with outputs in flight
        for (int n = 0; n < 64; n++) px[n] = n;
        run_line(10, 128, 0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_do", 32'(do_o), 32'd0);
        check("midrst_de", 32'(de_o), 32'd0);
        check("midrst_hs", 32'(hs_o), 32'd0);
        check("midrst_vs", 32'(vs_o), 32'd0);
        sb.delete();
        hist_hs = '0;
        hist_vs = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        line_check("cnt_after_rst", 24, 128, 0, 1'b1, 22);

        // Two frames of two lines each, random content
        vs_cnt = 0;
        for (int fr = 0; fr < 2; fr++) begin
            for (int ln = 0; ln < 2; ln++) begin
                for (int n = 0; n < 64; n++) px[n] = $urandom_range(0, 255);
                line_check("cnt_frame_line", 24, 179, 0, ln == 0, 16);
            end
        end
        check("vs_pulses", 32'(vs_cnt), 32'd2);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
